fbcpu_gen2: RTL and testbench

FBCPU_GEN2 -- requirements
Module: fbcpu_gen2

---
 rtl/fbcpu_gen2.sv | 149 ++++++++++++++
 tb/tb_fbcpu_gen2.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbcpu_gen2.sv
// Accumulator CPU sequencing FETCH/DECODE/MEM/HALT over a req/ack word memory port.
// Build option FBCPU_GEN2_MULDIV_EN enables MUL/DIV; without it opcodes 4-5 trap as illegal.
module fbcpu_gen2 #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,  OP_STORE = 4'd1,  OP_ADD   = 4'd2,  OP_SUB   = 4'd3,
    OP_MUL   = 4'd4,  OP_DIV   = 4'd5,  OP_JMP   = 4'd6,  OP_JZ    = 4'd7,
    OP_NOP   = 4'd8,  OP_HALT  = 4'd9,  OP_AND   = 4'd10, OP_OR    = 4'd11,
    OP_JN    = 4'd12, OP_LDI   = 4'd13, OP_ILL14 = 4'd14, OP_ILL15 = 4'd15
  } opcode_t;

  generate
    if (DATA_W < ADDR_W + 4) begin : g_bad_width
      $error("fbcpu_gen2: DATA_W must be at least ADDR_W+4");
    end
  endgenerate

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] alu;
  opcode_t           opcode;
  logic [ADDR_W-1:0] operand;
  logic              unused_ir;

  assign opcode    = opcode_t'(ir[DATA_W-1 -: 4]);
  assign operand   = ir[ADDR_W-1:0];
  assign unused_ir = ^ir;

  // Bus outputs are decoded from registered state only, and forced idle while rst is high.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_addr = operand;
          if (opcode == OP_STORE) begin
            mem_we    = 1'b1;
            mem_wdata = acc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu = acc;
    case (opcode)
      OP_LOAD: alu = mem_rdata;
      OP_ADD:  alu = acc + mem_rdata;
      OP_SUB:  alu = acc - mem_rdata;
      OP_AND:  alu = acc & mem_rdata;
      OP_OR:   alu = acc | mem_rdata;
`ifdef FBCPU_GEN2_MULDIV_EN
      OP_MUL:  alu = acc * mem_rdata;
      OP_DIV:  alu = (mem_rdata == '0) ? '1 : acc / mem_rdata;
`endif
      default: alu = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= '0;
      acc     <= '0;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: state <= S_MEM;
`ifdef FBCPU_GEN2_MULDIV_EN
            OP_MUL, OP_DIV: state <= S_MEM;
`endif
            OP_JMP: begin
              pc    <= operand;
              state <= S_FETCH;
            end
            OP_JZ: begin
              if (acc == '0) pc <= operand;
              state <= S_FETCH;
            end
            OP_JN: begin
              if (acc[DATA_W-1]) pc <= operand;
              state <= S_FETCH;
            end
            OP_NOP: state <= S_FETCH;
            OP_LDI: begin
              acc   <= {{(DATA_W-ADDR_W){1'b0}}, operand};
              state <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              illegal <= 1'b1;
              halted  <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            acc   <= alu;
            state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fbcpu_gen2.sv
// Scoreboard bench for fbcpu_gen2: directed programs push expected writes/halt snapshots,
// a monitor pops them when the DUT commits a write or enters HALT.
module tb_fbcpu_gen2;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 10;
  localparam int W_HALT = 576;

  logic              clk, rst;
  logic              mem_req, mem_ack, mem_we, halted, illegal;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, acc;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int pc; int acc; int ill; int cyc; } halt_t;

  wr_t   exp_wr[$];
  halt_t exp_halt[$];
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int delay;
  int cyc;
  int n_checks;
  int n_fail;

  fbcpu_gen2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .acc       (acc),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Memory responder: ack after `delay` wait cycles; with delay 0 ack is held high even when idle.
  initial begin : mem_model
    logic s_req, s_ack, s_we, s_rst;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    int cnt;
    cnt = 0;
    cyc = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      s_req = mem_req; s_ack = mem_ack; s_we = mem_we; s_rst = rst;
      s_addr = mem_addr; s_wdata = mem_wdata;
      @(posedge clk);
      if (s_req === 1'b1 && s_ack === 1'b1 && s_rst === 1'b0 && s_we === 1'b1) mem[s_addr] = s_wdata;
      if (s_req !== 1'b1 || s_ack === 1'b1) cnt = 0; else cnt++;
      if (s_rst !== 1'b0) cyc = 0; else cyc++;
      #3;
      mem_rdata = mem[mem_addr];
      mem_ack = (mem_req === 1'b1) ? (cnt >= delay) : (delay == 0);
    end
  end

  initial begin : monitor
    logic prev_wait, prev_halted, prev_we;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    wr_t w;
    halt_t h;
    prev_wait = 1'b0;
    prev_halted = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (prev_wait) begin
          check("wait_req_held", mem_req, 1);
          check("wait_addr_stable", mem_addr, prev_addr);
          check("wait_we_stable", mem_we, prev_we);
          check("wait_wdata_stable", mem_wdata, prev_wdata);
        end
        if (mem_req === 1'b1 && mem_ack === 1'b1 && mem_we === 1'b1) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", mem_addr, mem_wdata);
          end else begin
            w = exp_wr.pop_front();
            check("write_addr", mem_addr, w.addr);
            check("write_data", mem_wdata, w.data);
          end
        end
        if (halted === 1'b1 && !prev_halted) begin
          if (exp_halt.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_halt: got pc %0d acc %0d, expected no halt", pc, acc);
          end else begin
            h = exp_halt.pop_front();
            check("halt_pc", pc, h.pc);
            check("halt_acc", acc, h.acc);
            check("halt_illegal", illegal, h.ill);
            check("halt_cycles", cyc, h.cyc);
          end
        end
      end
      prev_wait   = (rst === 1'b0) && (mem_req === 1'b1) && (mem_ack !== 1'b1);
      prev_addr   = mem_addr;
      prev_we     = mem_we;
      prev_wdata  = mem_wdata;
      prev_halted = (halted === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_halt(input int p, input int a, input int ill, input int c);
    halt_t h;
    h.pc = p; h.acc = a; h.ill = ill; h.cyc = c;
    exp_halt.push_back(h);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
  endtask

  task automatic load_sum_prog();
    clear_mem();
    mem[0] = 10'd10;   mem[1] = 10'd139;  mem[2] = 10'd76;  mem[3] = 10'(W_HALT);
    mem[10] = 10'd300; mem[11] = 10'd500;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    tick();
    check("rst_pc", pc, 0);
    check("rst_acc", acc, 0);
    check("rst_illegal", illegal, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    #1;
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, 0);
  endtask

  task automatic run_to_halt(input int max_cyc);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check("halt_reached", halted, 1);
    tick();
    check("writes_drained", exp_wr.size(), 0);
    check("halts_drained", exp_halt.size(), 0);
    exp_wr.delete();
    exp_halt.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    delay = 0;
    tick();

    // LOAD/ADD/STORE/HALT with ack always high
    load_sum_prog();
    push_wr(12, 800);
    push_halt(4, 800, 0, 11);
    delay = 0;
    do_reset();
    run_to_halt(40);
    check("mem12_sum", mem[12], 800);

    // Same program, 3 wait cycles per access
    load_sum_prog();
    push_wr(12, 800);
    push_halt(4, 800, 0, 32);
    delay = 3;
    do_reset();
    run_to_halt(80);
    check("mem12_sum_wait", mem[12], 800);

    // JZ taken
    clear_mem();
    mem[0] = 10'd832; mem[1] = 10'd468; mem[20] = 10'(W_HALT);
    push_halt(21, 0, 0, 6);
    delay = 0;
    do_reset();
    run_to_halt(30);

    // JZ not taken
    clear_mem();
    mem[0] = 10'd837; mem[1] = 10'd478; mem[2] = 10'(W_HALT);
    push_halt(3, 5, 0, 6);
    do_reset();
    run_to_halt(30);

    // acc=1023, JN taken
    clear_mem();
    mem[0] = 10'd50; mem[1] = 10'd808; mem[40] = 10'(W_HALT); mem[50] = 10'd1023;
    push_halt(41, 1023, 0, 7);
    do_reset();
    run_to_halt(30);

    // SUB wraps negative, JN taken
    clear_mem();
    mem[0] = 10'd837; mem[1] = 10'd243; mem[2] = 10'd808; mem[40] = 10'(W_HALT); mem[51] = 10'd10;
    push_halt(41, 1019, 0, 9);
    do_reset();
    run_to_halt(30);

    // LDI 63, AND, OR, STORE with 1 wait cycle per access
    clear_mem();
    mem[0] = 10'd895; mem[1] = 10'd692; mem[2] = 10'd757; mem[3] = 10'd118; mem[4] = 10'(W_HALT);
    mem[52] = 10'd682; mem[53] = 10'd768;
    push_wr(54, 810);
    push_halt(5, 810, 0, 21);
    delay = 1;
    do_reset();
    run_to_halt(60);

    // Opcode 15 traps
    clear_mem();
    mem[0] = 10'd839; mem[1] = 10'd960;
    push_halt(2, 7, 1, 4);
    delay = 0;
    do_reset();
    run_to_halt(30);

    // MUL/DIV, or illegal trap when not built
    clear_mem();
    mem[55] = 10'd0; mem[56] = 10'd100; mem[57] = 10'd20;
`ifdef FBCPU_GEN2_MULDIV_EN
    mem[0] = 10'd839; mem[1] = 10'd375; mem[2] = 10'd122; mem[3] = 10'd56; mem[4] = 10'd313;
    mem[5] = 10'(W_HALT);
    push_wr(58, 1023);
    push_halt(6, 976, 0, 16);
`else
    mem[0] = 10'd839; mem[1] = 10'd313;
    push_halt(2, 7, 1, 4);
`endif
    do_reset();
    run_to_halt(40);

    // Reset during a fetch wait abandons it and restarts at address 0
    load_sum_prog();
    push_wr(12, 800);
    push_halt(4, 800, 0, 32);
    delay = 3;
    do_reset();
    tick();
    tick();
    check("pending_req", mem_req, 1);
    check("pending_pc", pc, 0);
    do_reset();
    run_to_halt(80);

    // Reset while halted
    do_reset();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
